// File: rtl/csr_exec_if.sv
// ----------------------------------------------------------------------------
// csr_exec_if -- bundle of the request, response and CSR-file signals of
// csr_exec.
//
//   Request   : req_valid, req_ready, req_funct3, req_addr, req_rs1_data,
//               req_uimm, req_src_zero
//   Response  : rsp_valid, rsp_ready, rsp_rdata, rsp_illegal
//   CSR file  : csr_addr, csr_op, csr_wr_en, csr_data_out, csr_data_in
//
// Modports:
//   slave  -- the csr_exec block itself
//   master -- the environment (pipeline plus CSR file)
// ----------------------------------------------------------------------------
interface csr_exec_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_rs1_data;
    logic [4:0]  req_uimm;
    logic        req_src_zero;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;

    logic [11:0] csr_addr;
    logic [2:0]  csr_op;
    logic        csr_wr_en;
    logic [31:0] csr_data_out;
    logic [31:0] csr_data_in;

    modport slave (
        input  req_valid, req_funct3, req_addr, req_rs1_data, req_uimm, req_src_zero,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_illegal,
        input  rsp_ready,
        output csr_addr, csr_op, csr_wr_en, csr_data_out,
        input  csr_data_in
    );

    modport master (
        output req_valid, req_funct3, req_addr, req_rs1_data, req_uimm, req_src_zero,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_illegal,
        output rsp_ready,
        input  csr_addr, csr_op, csr_wr_en, csr_data_out,
        output csr_data_in
    );
endinterface

// File: rtl/csr_exec.sv
// ----------------------------------------------------------------------------
// csr_exec -- executes one Zicsr instruction at a time as a four-state
// sequence: IDLE (accept) -> READ (sample old value) -> WRITE (one-cycle
// write strobe) -> RESP (hold old value until the pipeline takes it).
//
// Ports:
//   clk  -- rising-edge clock
//   rst  -- synchronous active-high reset; aborts any operation in flight
//   bus  -- csr_exec_if.slave: request handshake, response handshake and the
//           combinational-read / strobed-write CSR file interface
//
// Configuration:
//   CSR_RO_TRAP_EN -- when defined, a write that would really happen to an
//                     address with addr[11:10] == 2'b11 (read-only space) is
//                     turned into an illegal access with no write. When
//                     undefined, those addresses are written like any other.
// ----------------------------------------------------------------------------
module csr_exec (
    input  logic          clk,
    input  logic          rst,
    csr_exec_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] operand_q;   // rs1 data or zero-extended uimm, chosen at accept
    logic        src_zero_q;
    logic [31:0] old_q;       // CSR value sampled in READ
    logic        illegal_q;

    // Decode of the latched request against the current read data; only
    // consumed in READ, where csr_addr/csr_op already hold the request.
    logic        illegal_op;
    logic        zero_skip;
    logic        ro_trap;
    logic        do_write;
    logic [31:0] new_val;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        illegal_op = (bus.csr_op[1:0] == 2'b00);       // funct3 000 / 100
        // Set/clear forms (funct3[1] == 1) with a zero source do not write.
        zero_skip  = bus.csr_op[1] & src_zero_q;
`ifdef CSR_RO_TRAP_EN
        ro_trap    = (bus.csr_addr[11:10] == 2'b11) & ~illegal_op & ~zero_skip;
`else
        ro_trap    = 1'b0;
`endif
        do_write   = ~illegal_op & ~zero_skip & ~ro_trap;

        new_val = '0;
        case (bus.csr_op[1:0])
            2'b01:   new_val = operand_q;                       // RW / RWI
            2'b10:   new_val = bus.csr_data_in | operand_q;     // RS / RSI
            2'b11:   new_val = bus.csr_data_in & ~operand_q;    // RC / RCI
            default: new_val = '0;
        endcase
    end

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath registers are reset as well as the control
            // state, so an aborted operation leaves no stale data visible.
            state            <= IDLE;
            operand_q        <= '0;
            src_zero_q       <= 1'b0;
            old_q            <= '0;
            illegal_q        <= 1'b0;
            bus.req_ready    <= 1'b1;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_rdata    <= '0;
            bus.rsp_illegal  <= 1'b0;
            bus.csr_addr     <= '0;
            bus.csr_op       <= '0;
            bus.csr_wr_en    <= 1'b0;
            bus.csr_data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        state         <= READ;
                        bus.req_ready <= 1'b0;
                        // csr_addr/csr_op double as the latched request.
                        bus.csr_addr  <= bus.req_addr;
                        bus.csr_op    <= bus.req_funct3;
                        operand_q     <= bus.req_funct3[2] ? {27'b0, bus.req_uimm}
                                                           : bus.req_rs1_data;
                        src_zero_q    <= bus.req_src_zero;
                    end
                end

                READ: begin
                    state            <= WRITE;
                    old_q            <= bus.csr_data_in;
                    illegal_q        <= illegal_op | ro_trap;
                    bus.csr_wr_en    <= do_write;
                    // Data is shown only when the strobe is; otherwise zero.
                    bus.csr_data_out <= do_write ? new_val : '0;
                end

                WRITE: begin
                    state            <= RESP;
                    bus.csr_wr_en    <= 1'b0;
                    bus.csr_data_out <= '0;
                    bus.rsp_valid    <= 1'b1;
                    bus.rsp_rdata    <= old_q;
                    bus.rsp_illegal  <= illegal_q;
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        state           <= IDLE;
                        bus.req_ready   <= 1'b1;
                        bus.rsp_valid   <= 1'b0;
                        bus.rsp_rdata   <= '0;
                        bus.rsp_illegal <= 1'b0;
                        bus.csr_addr    <= '0;
                        bus.csr_op      <= '0;
                    end
                end
            endcase
        end
    end

endmodule
